// File: rtl/arc4_pkg.sv
// arc4_pkg: shared types and sizes for the ARC4 datapath stages.
package arc4_pkg;
   typedef enum logic {IDLE, WRITE} state_t;
   localparam int S_DEPTH = 256;
   localparam int DATA_W_DEF = 8;
endpackage

// File: rtl/init.sv
// init: sweeps S[i] = i for every address of the S memory on request.
module init
   import arc4_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   output logic              rdy,
   output logic [DATA_W-1:0] addr,
   output logic [DATA_W-1:0] wrdata,
   output logic              wren
);
   localparam logic [DATA_W-1:0] LAST = '1;
   state_t            r_state;
   logic              r_rdy;
   logic              r_wren;
   logic [DATA_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wrdata;
   // rst_n is active-high; terminal-count compare keeps the last write from wrapping to 0
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_state  <= IDLE;
         r_rdy    <= 1'b1;
         r_wren   <= 1'b0;
         r_addr   <= '0;
         r_wrdata <= '0;
      end else if (r_state == IDLE) begin
         if (en) begin
            r_state  <= WRITE;
            r_rdy    <= 1'b0;
            r_wren   <= 1'b1;
            r_addr   <= '0;
            r_wrdata <= '0;
         end
      end else if (r_addr == LAST) begin
         r_state  <= IDLE;
         r_rdy    <= 1'b1;
         r_wren   <= 1'b0;
         r_addr   <= '0;
         r_wrdata <= '0;
      end else begin
         r_addr   <= r_addr + 1'b1;
         r_wrdata <= r_addr + 1'b1;
      end
   end
   assign rdy    = r_rdy;
   assign wren   = r_wren;
   assign addr   = r_addr;
   assign wrdata = r_wrdata;
endmodule

// File: tb/tb_init.sv
// tb_init: checks init against a sweep-timing model and a RAM on its write port.
module tb_init;
   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       en = 1'b0;
   logic       rdy, wren;
   logic [7:0] addr, wrdata;
   int n_checks = 0;
   int n_fail = 0;
   bit chk_on = 1'b0;
   init #(.DATA_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy),
      .addr(addr), .wrdata(wrdata), .wren(wren)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask
   // model: a sweep started at edge s shows index (c - s) after edge c for 256 edges
   int cyc = 0;
   int m_start = -1000;
   function automatic bit m_busy(input int c);
      return (c - m_start >= 0) && (c - m_start < 256);
   endfunction
   always @(posedge clk or posedge rst_n) begin
      if (rst_n) m_start <= -1000;
      else begin
         cyc <= cyc + 1;
         if (!m_busy(cyc) && en) m_start <= cyc + 1;
      end
   end
   always @(negedge clk) begin
      if (chk_on) begin
         chk("m_rdy", rdy, !m_busy(cyc));
         chk("m_wren", wren, m_busy(cyc));
         chk("m_addr", addr, m_busy(cyc) ? cyc - m_start : 0);
         chk("m_wrdata", wrdata, m_busy(cyc) ? cyc - m_start : 0);
      end
   end
   logic [7:0] mem [256];
   int hits [256];
   int hit_base [256];
   int wr_cnt = 0;
   int wr_base = 0;
   initial for (int i = 0; i < 256; i++) hits[i] = 0;
   always @(posedge clk) begin
      if (wren === 1'b1) begin
         mem[addr]  <= wrdata;
         hits[addr] <= hits[addr] + 1;
         wr_cnt     <= wr_cnt + 1;
      end
   end
   task automatic snap();
      wr_base = wr_cnt;
      for (int i = 0; i < 256; i++) hit_base[i] = hits[i];
   endtask
   task automatic chk_sweeps(input string nm, input int n);
      int bad;
      bad = 0;
      for (int i = 0; i < 256; i++) if (hits[i] - hit_base[i] != n) bad++;
      chk({nm, "_count"}, wr_cnt - wr_base, 256 * n);
      chk({nm, "_per_addr_bad"}, bad, 0);
   endtask
   task automatic wait_addr(input int a);
      int k;
      k = 0;
      while (!(wren === 1'b1 && addr == 8'(a)) && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk("wait_addr_budget", k < 400, 1);
   endtask
   task automatic wait_idle();
      int k;
      k = 0;
      while (rdy !== 1'b1 && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk("wait_idle_budget", k < 400, 1);
   endtask
   task automatic pulse_en();
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
   endtask
   initial begin
      int bad, gaps;
      rst_n = 1'b0;
      #1 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      chk_on = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle_rdy", rdy, 1);
      chk("idle_wren", wren, 0);
      chk("idle_addr", addr, 0);
      chk("idle_wrdata", wrdata, 0);
      snap();
      pulse_en();
      chk("first_wren", wren, 1);
      chk("first_rdy", rdy, 0);
      chk("first_addr", addr, 0);
      chk("first_wrdata", wrdata, 0);
      repeat (255) @(negedge clk);
      chk("last_wren", wren, 1);
      chk("last_addr", addr, 255);
      chk("last_wrdata", wrdata, 255);
      @(negedge clk);
      chk("done_wren", wren, 0);
      chk("done_rdy", rdy, 1);
      chk("done_addr", addr, 0);
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== 8'(i)) bad++;
      chk("mem_contents_bad", bad, 0);
      chk_sweeps("sweep1", 1);
      snap();
      pulse_en();
      wait_addr(100);
      pulse_en();
      wait_idle();
      chk("midsweep_en_rdy", rdy, 1);
      chk_sweeps("midsweep", 1);
      pulse_en();
      wait_addr(128);
      #2 rst_n = 1'b1;
      #1;
      chk("rst_rdy", rdy, 1);
      chk("rst_wren", wren, 0);
      chk("rst_addr", addr, 0);
      chk("rst_wrdata", wrdata, 0);
      en = 1'b1;
      @(negedge clk);
      chk("rst_wins_wren", wren, 0);
      rst_n = 1'b0;
      en = 1'b0;
      @(negedge clk);
      chk("post_rst_idle", rdy, 1);
      snap();
      pulse_en();
      wait_idle();
      chk_sweeps("after_rst", 1);
      snap();
      gaps = 0;
      en = 1'b1;
      for (int k = 0; k < 770; k++) begin
         @(negedge clk);
         if (rdy === 1'b1) gaps++;
      end
      chk("held_last_addr", addr, 255);
      en = 1'b0;
      wait_idle();
      chk("held_idle_gaps", gaps, 2);
      chk_sweeps("held", 3);
      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
